// File: rtl/jtag_tap_multi.sv
// JTAG TAP controller with IDCODE, BYPASS and NUM_CH user DR channels.
// Each user channel presents its updated data on a valid/ready handshake.
// Optional feature macro: JTAG_TAP_OVERRUN_EN. When it is defined, an update
// that arrives while the previous one is still unconsumed is dropped and the
// channel's sticky overrun flag is set. When it is not defined, the new data
// overwrites the old data and ovr_o is tied to zero.
module jtag_tap_multi #(
  parameter logic [31:0] IDCODE_VAL = 32'hBADC0FFE,
  parameter int          IR_WIDTH   = 4,
  parameter int          NUM_CH     = 2,
  parameter int          DR_WIDTH   = 32
) (
  input  logic                       tck,
  input  logic                       trst,
  input  logic                       tms,
  input  logic                       tdi,
  output logic                       tdo,
  output logic                       tdo_en,
  output logic [3:0]                 tap_state_o,
  input  logic [NUM_CH*DR_WIDTH-1:0] cap_data_i,
  output logic [NUM_CH*DR_WIDTH-1:0] upd_data_o,
  output logic [NUM_CH-1:0]          upd_valid_o,
  input  logic [NUM_CH-1:0]          upd_ready_i,
  output logic [NUM_CH-1:0]          ovr_o
);

  typedef enum logic [3:0] {
    TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR = 4'd4, EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7,
    UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_USR_LO  = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_USR_END = IR_WIDTH'(NUM_CH + 2);

  tap_state_t            r_state;
  tap_state_t            w_state_next;
  logic [IR_WIDTH-1:0]   r_ir_sr;
  logic [IR_WIDTH-1:0]   r_ir;
  logic [31:0]           r_id_sr;
  logic                  r_bp_sr;
  logic [DR_WIDTH-1:0]   r_usr_sr;

  logic w_tlr, w_cap_dr, w_sh_dr, w_upd_dr, w_cap_ir, w_sh_ir, w_upd_ir;
  logic w_sel_id, w_sel_usr, w_dr_lsb;
  logic [NUM_CH-1:0]     w_ch_hit;
  logic [DR_WIDTH-1:0]   w_cap_usr;
  logic [DR_WIDTH-1:0]   w_usr_shift;
  logic [IR_WIDTH-1:0]   w_ir_shift;

  assign tap_state_o = r_state;

  // TAP state register
  always_ff @(posedge tck) begin
    if (trst) r_state <= TLR;
    else      r_state <= w_state_next;
  end

  // Standard tms-driven TAP transitions
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TLR:     w_state_next = tms ? TLR    : RTI;
      RTI:     w_state_next = tms ? SEL_DR : RTI;
      SEL_DR:  w_state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_state_next = tms ? EX1_DR : SH_DR;
      SH_DR:   w_state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  w_state_next = tms ? UPD_DR : PAU_DR;
      PAU_DR:  w_state_next = tms ? EX2_DR : PAU_DR;
      EX2_DR:  w_state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  w_state_next = tms ? SEL_DR : RTI;
      SEL_IR:  w_state_next = tms ? TLR    : CAP_IR;
      CAP_IR:  w_state_next = tms ? EX1_IR : SH_IR;
      SH_IR:   w_state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  w_state_next = tms ? UPD_IR : PAU_IR;
      PAU_IR:  w_state_next = tms ? EX2_IR : PAU_IR;
      EX2_IR:  w_state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  w_state_next = tms ? SEL_DR : RTI;
      default: w_state_next = TLR;
    endcase
  end

  // State decode strobes and the serial output mux
  always_comb begin
    w_tlr    = (r_state == TLR);
    w_cap_dr = (r_state == CAP_DR);
    w_sh_dr  = (r_state == SH_DR);
    w_upd_dr = (r_state == UPD_DR);
    w_cap_ir = (r_state == CAP_IR);
    w_sh_ir  = (r_state == SH_IR);
    w_upd_ir = (r_state == UPD_IR);
    tdo_en   = w_sh_dr | w_sh_ir;
    tdo      = 1'b0;
    if (w_sh_ir)      tdo = r_ir_sr[0];
    else if (w_sh_dr) tdo = w_dr_lsb;
  end

  // Instruction decode; anything that is not IDCODE or a user channel is BYPASS
  always_comb begin
    w_sel_id  = (r_ir == IR_IDCODE);
    w_sel_usr = (r_ir >= IR_USR_LO) && (r_ir < IR_USR_END);
    w_dr_lsb  = w_sel_id ? r_id_sr[0] : (w_sel_usr ? r_usr_sr[0] : r_bp_sr);
    w_cap_usr = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch_hit[n]) w_cap_usr = cap_data_i[n*DR_WIDTH +: DR_WIDTH];
    end
    // Shift right with tdi into the MSB; written this way so width 1 works
    w_usr_shift = r_usr_sr >> 1;
    w_usr_shift[DR_WIDTH-1] = tdi;
    w_ir_shift = r_ir_sr >> 1;
    w_ir_shift[IR_WIDTH-1] = tdi;
  end

  // Instruction shift register and active instruction
  always_ff @(posedge tck) begin
    if (trst) begin
      r_ir_sr <= '0;
      r_ir    <= IR_IDCODE;
    end else begin
      if (w_cap_ir)     r_ir_sr <= IR_WIDTH'(1);
      else if (w_sh_ir) r_ir_sr <= w_ir_shift;
      if (w_tlr)         r_ir <= IR_IDCODE;
      else if (w_upd_ir) r_ir <= r_ir_sr;
    end
  end

  // Data shift registers; only the selected one captures or shifts.
  // All user channels share one shift register since only one is selected.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_id_sr  <= '0;
      r_bp_sr  <= 1'b0;
      r_usr_sr <= '0;
    end else if (w_cap_dr) begin
      if (w_sel_id)       r_id_sr  <= IDCODE_VAL;
      else if (w_sel_usr) r_usr_sr <= w_cap_usr;
      else                r_bp_sr  <= 1'b0;
    end else if (w_sh_dr) begin
      if (w_sel_id)       r_id_sr  <= {tdi, r_id_sr[31:1]};
      else if (w_sel_usr) r_usr_sr <= w_usr_shift;
      else                r_bp_sr  <= tdi;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                r_valid;
      logic [DR_WIDTH-1:0] r_data;
      logic                w_upd;
      logic                w_rdy;

      assign w_ch_hit[gi] = (r_ir == IR_WIDTH'(gi + 2));
      assign w_upd        = w_upd_dr & w_ch_hit[gi];
      assign w_rdy        = upd_ready_i[gi];
      assign upd_valid_o[gi] = r_valid;
      assign upd_data_o[gi*DR_WIDTH +: DR_WIDTH] = r_data;

`ifdef JTAG_TAP_OVERRUN_EN
      logic r_ovr;
      assign ovr_o[gi] = r_ovr;

      // Update handshake; an unconsumed update blocks new data and flags overrun
      always_ff @(posedge tck) begin
        if (trst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_ovr   <= 1'b0;
        end else begin
          if (w_upd && r_valid && !w_rdy) begin
            r_ovr <= 1'b1;
          end else if (w_upd) begin
            r_data  <= r_usr_sr;
            r_valid <= 1'b1;
          end else if (w_rdy) begin
            r_valid <= 1'b0;
          end
          if (w_tlr) r_ovr <= 1'b0;
        end
      end
`else
      assign ovr_o[gi] = 1'b0;

      // Update handshake; a new update always overwrites the held data
      always_ff @(posedge tck) begin
        if (trst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_upd) begin
          r_data  <= r_usr_sr;
          r_valid <= 1'b1;
        end else if (w_rdy) begin
          r_valid <= 1'b0;
        end
      end
`endif
    end
  endgenerate

endmodule
